// File: rtl/spi_frame_receiver_pkg.sv
// Shared definitions for the SPI frame receiver: field widths, default frame
// length and the receiver state encoding.
package spi_frame_receiver_pkg;

    localparam int SPI_ADDR_W      = 8;
    localparam int SPI_VAL_W       = 8;
    localparam int SPI_DEFAULT_MSB = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_ABORT = 2'd2
    } spi_state_t;

endpackage

// File: rtl/spi_input_sync.sv
// Multi-stage synchroniser for one asynchronous SPI pin, followed by a
// registered rise/fall edge detector.
//   clk, rst  system clock, async active-high reset
//   pin       raw asynchronous input
//   level     synchronised level, time-aligned with the rise/fall flags
//   rise/fall one-cycle edge flags
//   at_idle   every flop of the chain holds the idle (reset) level
module spi_input_sync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic pin,
    output logic level,
    output logic rise,
    output logic fall,
    output logic at_idle
);

    logic [STAGES-1:0] chain;
    logic              level_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain   <= {STAGES{RST_VAL}};
            level_d <= RST_VAL;
            rise    <= 1'b0;
            fall    <= 1'b0;
        end else begin
            chain   <= {chain[STAGES-2:0], pin};
            level_d <= chain[STAGES-1];
            rise    <= chain[STAGES-1] & ~level_d;
            fall    <= ~chain[STAGES-1] & level_d;
        end
    end

    assign level   = level_d;
    assign at_idle = (chain == {STAGES{RST_VAL}}) && (level_d == RST_VAL);

endmodule

// File: rtl/spi_frame_receiver.sv
// SPI slave front-end: oversamples SCLK/CS/SPECIAL/MOSI on clk, deserialises
// MSB-bit frames into an addr/val pair and shifts readback data out on MISO.
//   clk, rst             system clock, async active-high reset
//   spi_clk/cs/special/mosi  raw SPI pins (cs, special active low)
//   spi_miso             readback bit, 0 outside SHIFT
//   rd_data              readback word, sampled at frame start
//   frame_valid/err      one-cycle result strobes
//   frame_addr/val       decoded fields, held until next frame_valid
//   busy                 high while shifting
//
// state | meaning
// IDLE  | waiting for CS fall with SPECIAL low
// SHIFT | frame in progress, bits counted on SCLK fall
// ABORT | after reset or SPECIAL release; waits for CS to settle high
module spi_frame_receiver
    import spi_frame_receiver_pkg::*;
#(
    parameter int MSB         = SPI_DEFAULT_MSB,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  spi_clk,
    input  logic                  spi_cs,
    input  logic                  spi_special,
    input  logic                  spi_mosi,
    output logic                  spi_miso,
    input  logic [MSB-1:0]        rd_data,
    output logic                  frame_valid,
    output logic [SPI_ADDR_W-1:0] frame_addr,
    output logic [SPI_VAL_W-1:0]  frame_val,
    output logic                  frame_err,
    output logic                  busy
);

    localparam int CNT_MAX = (MSB + 1 > SYNC_STAGES + 1) ? MSB + 1 : SYNC_STAGES + 1;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_FULL   = CNT_W'(MSB);
    localparam logic [CNT_W-1:0] CNT_SAT    = CNT_W'(MSB + 1);
    // A reset can release while the CS pin is already low but not yet
    // sampled; requiring the whole chain to read high this long keeps a
    // reset mid-frame from being mistaken for a fresh CS fall.
    localparam logic [CNT_W-1:0] CNT_SETTLE = CNT_W'(SYNC_STAGES + 1);

    logic s_cs, cs_rise, cs_fall, cs_at_idle;
    logic s_special, special_rise;
    logic clk_rise, clk_fall;
    logic s_mosi;
    logic clk_level_unused, clk_at_idle_unused;
    logic special_fall_unused, special_at_idle_unused;
    logic mosi_rise_unused, mosi_fall_unused, mosi_at_idle_unused;

    spi_input_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
        .clk(clk), .rst(rst), .pin(spi_cs),
        .level(s_cs), .rise(cs_rise), .fall(cs_fall), .at_idle(cs_at_idle)
    );
    spi_input_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_special (
        .clk(clk), .rst(rst), .pin(spi_special),
        .level(s_special), .rise(special_rise), .fall(special_fall_unused),
        .at_idle(special_at_idle_unused)
    );
    spi_input_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_clk (
        .clk(clk), .rst(rst), .pin(spi_clk),
        .level(clk_level_unused), .rise(clk_rise), .fall(clk_fall),
        .at_idle(clk_at_idle_unused)
    );
    spi_input_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .rst(rst), .pin(spi_mosi),
        .level(s_mosi), .rise(mosi_rise_unused), .fall(mosi_fall_unused),
        .at_idle(mosi_at_idle_unused)
    );

    spi_state_t       state, state_nxt;
    logic [CNT_W-1:0] count;
    logic [MSB-1:0]   shreg_in;
    logic [MSB-1:0]   shreg_out;
    logic             load_out, valid_set, err_set;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_ABORT;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        load_out  = 1'b0;
        valid_set = 1'b0;
        err_set   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (cs_fall && !s_special) begin
                    state_nxt = ST_SHIFT;
                    load_out  = 1'b1;
                end
            end
            ST_SHIFT: begin
                // CS rise takes priority over any SCLK edge in the same cycle.
                if (cs_rise) begin
                    state_nxt = ST_IDLE;
                    if (count == CNT_FULL) valid_set = 1'b1;
                    else                   err_set   = 1'b1;
                end else if (special_rise && !s_cs) begin
                    state_nxt = ST_ABORT;
                    err_set   = 1'b1;
                end
            end
            ST_ABORT: begin
                if (count == CNT_SETTLE) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_ABORT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count       <= '0;
            shreg_in    <= '0;
            shreg_out   <= '0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            frame_addr  <= '0;
            frame_val   <= '0;
        end else begin
            frame_valid <= valid_set;
            frame_err   <= err_set;
            if (valid_set) begin
                frame_addr <= shreg_in[SPI_VAL_W +: SPI_ADDR_W];
                frame_val  <= shreg_in[SPI_VAL_W-1:0];
            end
            case (state)
                ST_IDLE: begin
                    if (load_out) begin
                        shreg_out <= rd_data;
                        shreg_in  <= '0;
                        count     <= '0;
                    end
                end
                ST_SHIFT: begin
                    if (state_nxt == ST_ABORT) begin
                        count <= '0;
                    end else if (!cs_rise) begin
                        if (clk_fall) begin
                            shreg_in <= {shreg_in[MSB-2:0], s_mosi};
                            if (count != CNT_SAT) count <= count + 1'b1;
                        end
                        if (clk_rise) shreg_out <= {shreg_out[MSB-2:0], 1'b0};
                    end
                end
                ST_ABORT: begin
                    if (!cs_at_idle)              count <= '0;
                    else if (count != CNT_SETTLE) count <= count + 1'b1;
                end
                default: count <= '0;
            endcase
        end
    end

    assign busy     = (state == ST_SHIFT);
    assign spi_miso = (state == ST_SHIFT) & shreg_out[MSB-1];

endmodule

// File: tb/tb_spi_frame_receiver.sv
module tb_spi_frame_receiver;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        spi_clk = 1'b0;
    logic        spi_cs = 1'b1;
    logic        spi_special = 1'b1;
    logic        spi_mosi = 1'b0;
    logic        spi_miso;
    logic [15:0] rd_data = 16'h0000;
    logic        frame_valid;
    logic [7:0]  frame_addr;
    logic [7:0]  frame_val;
    logic        frame_err;
    logic        busy;

    int tests = 0;
    int fails = 0;

    typedef struct packed {
        logic       err;
        logic [7:0] addr;
        logic [7:0] val;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    spi_frame_receiver dut (
        .clk(clk), .rst(rst),
        .spi_clk(spi_clk), .spi_cs(spi_cs), .spi_special(spi_special),
        .spi_mosi(spi_mosi), .spi_miso(spi_miso), .rd_data(rd_data),
        .frame_valid(frame_valid), .frame_addr(frame_addr), .frame_val(frame_val),
        .frame_err(frame_err), .busy(busy)
    );

    always #5 clk = ~clk;

    // Scoreboard: every strobe must match the oldest queued expectation.
    always @(posedge clk) begin
        #1;
        if (frame_valid || frame_err) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_event: valid=%0b err=%0b, required no strobe", frame_valid, frame_err);
            end else begin
                mon_e = exp_q.pop_front();
                if (frame_valid === frame_err || frame_err !== mon_e.err ||
                    (!mon_e.err && (frame_addr !== mon_e.addr || frame_val !== mon_e.val))) begin
                    fails++;
                    $display("FAIL frame_result: valid=%0b err=%0b addr=%h val=%h, required err=%0b addr=%h val=%h",
                             frame_valid, frame_err, frame_addr, frame_val, mon_e.err, mon_e.addr, mon_e.val);
                end
            end
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_exp(input logic err, input logic [7:0] addr, input logic [7:0] val);
        exp_t e;
        e.err = err; e.addr = addr; e.val = val;
        exp_q.push_back(e);
    endtask

    task automatic check_drained(input string name);
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL %s_drained: %0d expectations pending, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic send_bits(input logic [31:0] word, input int nbits, input int from, input int to,
                             input bit chk_miso, input logic [15:0] exp_miso);
        for (int i = from; i < to; i++) begin
            spi_mosi = word[nbits-1-i];
            if (chk_miso) begin
                tests++;
                if (spi_miso !== exp_miso[15-i]) begin
                    fails++;
                    $display("FAIL miso_bit%0d: got %0b, required %0b", i, spi_miso, exp_miso[15-i]);
                end
            end
            spi_clk = 1'b1;
            wait_clk(4);
            spi_clk = 1'b0;
            wait_clk(4);
        end
    endtask

    task automatic frame(input logic [31:0] word, input int nbits);
        spi_cs = 1'b0;
        wait_clk(8);
        send_bits(word, nbits, 0, nbits, 1'b0, 16'h0);
        spi_cs = 1'b1;
        wait_clk(16);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if ({spi_miso, frame_valid, frame_err, busy, frame_addr, frame_val} !== 20'h0) begin
            fails++;
            $display("FAIL reset_outputs: miso=%0b valid=%0b err=%0b busy=%0b addr=%h val=%h, required all 0",
                     spi_miso, frame_valid, frame_err, busy, frame_addr, frame_val);
        end
        @(negedge clk);
        rst = 1'b0;
        spi_special = 1'b0;
        wait_clk(16);
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_busy: got %0b, required 0", busy);
        end
    endtask

    task automatic test_basic();
        push_exp(1'b0, 8'h07, 8'h05);
        spi_cs = 1'b0;
        wait_clk(8);
        send_bits(32'h0705, 16, 0, 16, 1'b0, 16'h0);
        spi_cs = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if (frame_valid !== 1'b0) begin
            fails++;
            $display("FAIL latency_early: valid=%0b at 3 clk, required 0", frame_valid);
        end
        @(posedge clk);
        #1;
        tests++;
        if (frame_valid !== 1'b1) begin
            fails++;
            $display("FAIL latency_on_time: valid=%0b at 4 clk, required 1", frame_valid);
        end
        wait_clk(16);
        check_drained("basic");
    endtask

    task automatic test_miso();
        rd_data = 16'hA5C3;
        push_exp(1'b0, 8'h12, 8'h34);
        spi_cs = 1'b0;
        wait_clk(8);
        rd_data = 16'hFFFF;
        send_bits(32'h1234, 16, 0, 16, 1'b1, 16'hA5C3);
        spi_cs = 1'b1;
        wait_clk(16);
        tests++;
        if (spi_miso !== 1'b0) begin
            fails++;
            $display("FAIL miso_idle: got %0b, required 0", spi_miso);
        end
        check_drained("miso");
    endtask

    task automatic test_length();
        push_exp(1'b1, 8'h00, 8'h00);
        frame(32'h7FFF, 15);
        push_exp(1'b1, 8'h00, 8'h00);
        frame(32'h1FFFF, 17);
        check_drained("length");
        tests++;
        if (frame_addr !== 8'h12 || frame_val !== 8'h34) begin
            fails++;
            $display("FAIL length_retain: addr=%h val=%h, required addr=12 val=34", frame_addr, frame_val);
        end
    endtask

    task automatic test_special_high();
        spi_special = 1'b1;
        wait_clk(8);
        spi_cs = 1'b0;
        for (int i = 0; i < 16; i++) begin
            spi_mosi = i[0];
            spi_clk = 1'b1;
            for (int k = 0; k < 8; k++) begin
                if (k == 4) spi_clk = 1'b0;
                wait_clk(1);
                tests++;
                if (busy !== 1'b0 || spi_miso !== 1'b0) begin
                    fails++;
                    $display("FAIL special_high bit%0d: busy=%0b miso=%0b, required 0 0", i, busy, spi_miso);
                end
            end
        end
        spi_cs = 1'b1;
        wait_clk(16);
        spi_special = 1'b0;
        wait_clk(16);
        check_drained("special_high");
    endtask

    task automatic test_special_release();
        push_exp(1'b1, 8'h00, 8'h00);
        spi_cs = 1'b0;
        wait_clk(8);
        send_bits(32'hFFFF, 16, 0, 8, 1'b0, 16'h0);
        spi_special = 1'b1;
        wait_clk(12);
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL special_abort_busy: got %0b, required 0", busy);
        end
        spi_cs = 1'b1;
        wait_clk(16);
        spi_special = 1'b0;
        wait_clk(16);
        push_exp(1'b0, 8'h0A, 8'h0F);
        frame(32'h0A0F, 16);
        check_drained("special_release");
    endtask

    task automatic test_reset_midframe();
        spi_cs = 1'b0;
        wait_clk(8);
        send_bits(32'hC3C3, 16, 0, 8, 1'b0, 16'h0);
        rst = 1'b1;
        wait_clk(2);
        tests++;
        if ({spi_miso, frame_valid, frame_err, busy, frame_addr, frame_val} !== 20'h0) begin
            fails++;
            $display("FAIL midframe_reset_outputs: miso=%0b busy=%0b addr=%h val=%h, required all 0",
                     spi_miso, busy, frame_addr, frame_val);
        end
        rst = 1'b0;
        send_bits(32'hC3C3, 16, 8, 16, 1'b0, 16'h0);
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL midframe_busy: got %0b, required 0", busy);
        end
        spi_cs = 1'b1;
        wait_clk(16);
        check_drained("midframe_ignore");
        push_exp(1'b0, 8'h0B, 8'h00);
        frame(32'h0B00, 16);
        check_drained("midframe_next");
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 3; n++) begin
            logic [15:0] w;
            w = 16'($urandom_range(0, 16'hFFFF));
            push_exp(1'b0, w[15:8], w[7:0]);
            frame({16'h0, w}, 16);
        end
        check_drained("back_to_back");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_miso();
        test_length();
        test_special_high();
        test_special_release();
        test_reset_midframe();
        test_back_to_back();
        wait_clk(20);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
